// File: rtl/sha_msg_mem.sv
// Word-organised message memory serving the SHA-256 core read port, plus a host byte-masked write port.
// Latency: RD_LAT cycles from an accepted request to its mem_data_vld pulse. Responses return in request order.
// Backpressure: none. Every mem_addr_vld cycle is accepted, and back-to-back requests run at full rate.
//
// Ports:
//   clk_axi, rst              clock and synchronous active-high reset
//   mem_addr_vld, mem_addr    read request strobe and byte address
//   mem_data_vld, mem_data    read response strobe and data (data is 0 whenever the strobe is low)
//   wr_en, wr_addr, wr_data,  host write: word index, data and per-byte enables
//   wr_be
//   par_inj                   parity-flip mask applied on write (parity build only)
//   err_clr                   clears the sticky rd_err/par_err flags (a same-cycle set wins)
//   rd_err, par_err           sticky address-error and parity-error flags
//   rd_count                  saturating count of accepted read requests
//
// Optional build macro SHA_MEM_PARITY_EN: stores per-byte even parity and checks it on every good read.
module sha_msg_mem #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_axi,
  input  logic              rst,
  input  logic              mem_addr_vld,
  input  logic [31:0]       mem_addr,
  output logic              mem_data_vld,
  output logic [31:0]       mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  input  logic [3:0]        par_inj,
  input  logic              err_clr,
  output logic              rd_err,
  output logic              par_err,
  output logic [31:0]       rd_count
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  // Byte size of the window, held in 33 bits so that the largest legal ADDR_W cannot overflow it.
  localparam logic [32:0] LIMIT = 33'd4 << ADDR_W;

  if (RD_LAT == 0 || RD_LAT > 4) begin : g_bad_lat
    $error("sha_msg_mem: RD_LAT must be within 1..4");
  end
  if ((BASE_ADDR % 4) != 0) begin : g_bad_base
    $error("sha_msg_mem: BASE_ADDR must be 4-byte aligned");
  end
  if (ADDR_W == 0 || ADDR_W > 30) begin : g_bad_aw
    $error("sha_msg_mem: ADDR_W must be within 1..30");
  end

  // Address decode
  logic [31:0]       off;
  logic              rd_bad;
  logic [ADDR_W-1:0] rd_widx;

  assign off     = mem_addr - BASE_ADDR;
  assign rd_bad  = (mem_addr[1:0] != 2'b00) || (mem_addr < BASE_ADDR) || ({1'b0, off} >= LIMIT);
  assign rd_widx = off[ADDR_W+1:2];

  // Block RAM with a registered output. The non-blocking read of the old word gives
  // read-first behaviour when a read and a write hit the same word in one cycle.
  logic [31:0] mem_q [DEPTH];
  logic [31:0] ram_q;

  always_ff @(posedge clk_axi) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (mem_addr_vld) ram_q <= mem_q[rd_widx];
  end

  // Valid shift pipeline. Stage 0 lines up with the RAM output register.
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              err_q;
  logic [31:0]       stg0_dat;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = mem_addr_vld;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge clk_axi) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (mem_addr_vld) err_q <= rd_bad;
    end
  end

  // Gate the RAM word here, so that every later stage carries 0 for idle and errored slots.
  assign stg0_dat     = (vld_q[0] && !err_q) ? ram_q : 32'h0;
  assign mem_data_vld = vld_q[RD_LAT-1];

  if (RD_LAT == 1) begin : g_lat1
    assign mem_data = stg0_dat;
  end else begin : g_latn
    logic [31:0] dat_q [1:RD_LAT-1];
    always_ff @(posedge clk_axi) begin
      if (rst) begin
        for (int i = 1; i < RD_LAT; i++) dat_q[i] <= 32'h0;
      end else begin
        dat_q[1] <= stg0_dat;
        for (int i = 2; i < RD_LAT; i++) dat_q[i] <= dat_q[i-1];
      end
    end
    assign mem_data = dat_q[RD_LAT-1];
  end

  // Sticky address error and saturating request counter
  logic        rd_err_q;
  logic [31:0] rd_count_q;

  always_ff @(posedge clk_axi) begin
    if (rst) begin
      rd_err_q   <= 1'b0;
      rd_count_q <= 32'h0;
    end else begin
      if (mem_addr_vld && rd_bad) rd_err_q <= 1'b1;
      else if (err_clr)           rd_err_q <= 1'b0;
      if (mem_addr_vld && (rd_count_q != 32'hFFFF_FFFF)) rd_count_q <= rd_count_q + 32'd1;
    end
  end

  assign rd_err   = rd_err_q;
  assign rd_count = rd_count_q;

`ifdef SHA_MEM_PARITY_EN
  // Parity side array. It is written and read alongside the data array and checked at stage 0.
  logic [3:0] par_mem_q [DEPTH];
  logic [3:0] par_rd_q;
  logic [3:0] par_calc;
  logic       par_bad;
  logic       par_err_q;

  always_ff @(posedge clk_axi) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) par_mem_q[wr_addr][i] <= (^wr_data[8*i +: 8]) ^ par_inj[i];
      end
    end
    if (mem_addr_vld) par_rd_q <= par_mem_q[rd_widx];
  end

  always_comb begin
    par_calc = '0;
    for (int i = 0; i < 4; i++) par_calc[i] = ^ram_q[8*i +: 8];
  end

  assign par_bad = vld_q[0] && !err_q && (par_calc != par_rd_q);

  always_ff @(posedge clk_axi) begin
    if (rst)          par_err_q <= 1'b0;
    else if (par_bad) par_err_q <= 1'b1;
    else if (err_clr) par_err_q <= 1'b0;
  end

  assign par_err = par_err_q;
`else
  logic unused_par_inj;
  assign unused_par_inj = ^par_inj;
  assign par_err        = 1'b0;
`endif

endmodule
